// File: rtl/nec_ir_pkg.sv
// NEC IR transmitter shared definitions: FSM states, NEC timing in units, frame size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// IR_REPEAT_EN adds the repeat-code states (REP_MARK, REP_SPACE, REP_STOP).
package nec_ir_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEADER_MARK,
    LEADER_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
`ifdef IR_REPEAT_EN
    ,
    REP_MARK,
    REP_SPACE,
    REP_STOP
`endif
  } state_t;

  // NEC durations, in 562.5 us units
  localparam int LEADER_MARK_U  = 16;
  localparam int LEADER_SPACE_U = 8;
  localparam int BIT_MARK_U     = 1;
  localparam int ZERO_SPACE_U   = 1;
  localparam int ONE_SPACE_U    = 3;
  localparam int STOP_U         = 1;
  localparam int REP_SPACE_U    = 4;

  localparam int NEC_BITS = 32;

  // States during which the LED carries the modulated carrier.
  function automatic logic is_mark(input state_t s);
    case (s)
      LEADER_MARK, BIT_MARK, STOP_MARK: return 1'b1;
`ifdef IR_REPEAT_EN
      REP_MARK, REP_STOP: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Gated carrier generator: 50% duty square wave at clk/CARRIER_DIV, forced low when disabled.
// Latency: 1 cycle, registered output; phase 0 (high) appears the cycle after restart.
// Backpressure: none, free-running while enabled.
// Ports: clk, rst_n (async active-low), enable (carrier allowed next cycle),
//        restart (start a new mark at phase 0), carrier (registered LED drive).
module ir_carrier_gen #(
  parameter int CARRIER_DIV = 1316
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic carrier
);

  localparam int CW = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] CAR_HALF = CW'(CARRIER_DIV / 2);
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_DIV - 1);

  logic [CW-1:0] car_cnt;
  logic [CW-1:0] phase;

  // restart overrides the running count so every mark begins with a high half-period
  assign phase = restart ? '0 : car_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_cnt <= '0;
      carrier <= 1'b0;
    end else begin
      carrier <= enable && (phase < CAR_HALF);
      if (!enable || phase == CAR_LAST) begin
        car_cnt <= '0;
      end else begin
        car_cnt <= phase + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: takes an addr/cmd pair, sends leader + 32 bits LSB first + stop on a 38 kHz carrier.
// Latency: ir_led rises the cycle after the transfer edge; one frame per FRAME_UNITS units.
// Backpressure: tx_ready high only in IDLE; requests seen while busy are dropped, not queued.
// Ports: clk, rst_n (async active-low), tx_valid/tx_ready handshake, tx_addr, tx_cmd,
//        tx_hold (repeat request), busy (= ~tx_ready), ir_led (registered, modulated).
// IR_REPEAT_EN: when defined, a held key (tx_hold) emits NEC repeat codes every frame period.
module nec_ir_transmitter #(
  parameter int UNIT_CYCLES = 28125,
  parameter int CARRIER_DIV = 1316,
  parameter int FRAME_UNITS = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  input  logic       tx_hold,
  output logic       busy,
  output logic       ir_led
);

  import nec_ir_pkg::*;

  localparam int UW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_UNITS - 1);
  localparam logic [7:0] FRAME_MAX  = 8'(FRAME_UNITS);

  state_t state, state_n;

  logic [UW-1:0]       unit_cnt;
  logic [4:0]          dur_cnt;      // whole units spent in the current state
  logic [4:0]          dur_u;        // length of the current state in units
  logic [4:0]          bit_idx;
  logic [7:0]          frame_units;  // units since leader (or repeat mark) start
  logic [NEC_BITS-1:0] payload;      // bit 0 is always the bit being sent
  logic                unit_tick;
  logic                last_unit;
  logic                xfer;
  logic                frame_rst;
  logic                mark_n;

  assign tx_ready  = (state == IDLE);
  assign busy      = ~tx_ready;
  assign xfer      = tx_valid && tx_ready;
  assign unit_tick = (state != IDLE) && (unit_cnt == UNIT_LAST);
  assign last_unit = unit_tick && (dur_cnt == dur_u - 5'd1);
  // the frame period is re-based both for a new frame and for each repeat code
  assign frame_rst = xfer || (state == GAP && is_mark(state_n));

  always_comb begin
    dur_u = 5'(BIT_MARK_U);
    case (state)
      LEADER_MARK:  dur_u = 5'(LEADER_MARK_U);
      LEADER_SPACE: dur_u = 5'(LEADER_SPACE_U);
      BIT_MARK:     dur_u = 5'(BIT_MARK_U);
      BIT_SPACE:    dur_u = payload[0] ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
      STOP_MARK:    dur_u = 5'(STOP_U);
`ifdef IR_REPEAT_EN
      REP_MARK:     dur_u = 5'(LEADER_MARK_U);
      REP_SPACE:    dur_u = 5'(REP_SPACE_U);
      REP_STOP:     dur_u = 5'(STOP_U);
`endif
      default:      dur_u = 5'(BIT_MARK_U);
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:         if (tx_valid) state_n = LEADER_MARK;
      LEADER_MARK:  if (last_unit) state_n = LEADER_SPACE;
      LEADER_SPACE: if (last_unit) state_n = BIT_MARK;
      BIT_MARK:     if (last_unit) state_n = BIT_SPACE;
      BIT_SPACE: begin
        if (last_unit) begin
          state_n = (bit_idx == 5'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK:    if (last_unit) state_n = GAP;
      GAP: begin
        if (unit_tick && frame_units == FRAME_LAST) begin
`ifdef IR_REPEAT_EN
          state_n = tx_hold ? REP_MARK : IDLE;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef IR_REPEAT_EN
      REP_MARK:     if (last_unit) state_n = REP_SPACE;
      REP_SPACE:    if (last_unit) state_n = REP_STOP;
      REP_STOP:     if (last_unit) state_n = GAP;
`endif
      default:      state_n = IDLE;
    endcase
  end

`ifndef IR_REPEAT_EN
  logic unused_hold;
  assign unused_hold = tx_hold;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_cnt    <= '0;
      dur_cnt     <= '0;
      bit_idx     <= '0;
      frame_units <= '0;
      payload     <= '0;
    end else begin
      if (state == IDLE || state_n == IDLE || unit_tick) begin
        unit_cnt <= '0;
      end else begin
        unit_cnt <= unit_cnt + UW'(1);
      end

      if (state_n != state) begin
        dur_cnt <= '0;
      end else if (unit_tick) begin
        dur_cnt <= dur_cnt + 5'd1;
      end

      if (xfer) begin
        payload <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
        bit_idx <= '0;
      end else if (state == BIT_SPACE && last_unit) begin
        payload <= payload >> 1;
        bit_idx <= bit_idx + 5'd1;
      end

      if (frame_rst) begin
        frame_units <= '0;
      end else if (unit_tick && frame_units != FRAME_MAX) begin
        frame_units <= frame_units + 8'd1;
      end
    end
  end

  // carrier decisions use the next state so the LED lights on the first cycle of a mark
  assign mark_n = is_mark(state_n);

  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (mark_n),
    .restart(mark_n && (state_n != state)),
    .carrier(ir_led)
  );

endmodule
